// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order ready/valid fetches and queues {addr, inst} for decode.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned redirect sets sticky fetch_error and halts fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic        rom_ready,
    input  logic        rom_rvalid,
    input  logic [31:0] rom_rdata,
    output logic        id_valid,
    output logic [31:0] id_addr,
    output logic [31:0] id_inst,
    output logic        fetch_error
);

    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(QUEUE_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};

    logic [31:0]   pc_r;
    logic [31:0]   resp_addr_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] out_r;
    logic [CW-1:0] disc_r;
    logic [31:0]   addr_mem_r [QUEUE_DEPTH];
    logic [31:0]   inst_mem_r [QUEUE_DEPTH];

    logic          take_s;
    logic          redirect_s;
    logic [CW:0]   occupancy_s;
    logic          rom_en_s;
    logic          accept_s;
    logic          discard_s;
    logic          push_s;
    logic          halt_s;
    logic [31:0]   target_s;
    logic [CW-1:0] disc_reload_s;

    assign id_valid = (count_r != CNT_ZERO);
    assign rom_addr = pc_r;
    assign rom_en   = rom_en_s;
    assign target_s = branch_addr & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    logic halted_r;
    logic fetch_error_r;
    logic misalign_s;

    assign halt_s      = halted_r;
    assign fetch_error = fetch_error_r;
    assign misalign_s  = (branch_addr[1:0] != 2'b00);

    // Sticky misalignment error and fetch halt, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_r      <= 1'b0;
            fetch_error_r <= 1'b0;
        end else if (redirect_s && misalign_s) begin
            halted_r      <= 1'b1;
            fetch_error_r <= 1'b1;
        end else begin
            halted_r      <= halted_r;
            fetch_error_r <= fetch_error_r;
        end
    end
`else
    assign halt_s      = 1'b0;
    assign fetch_error = 1'b0;
`endif

    // Consume/redirect decode and the issue rule bounding in-flight plus queued fetches.
    always_comb begin
        take_s      = id_valid & ~stall;
        redirect_s  = branch_flag & take_s;
        occupancy_s = {1'b0, out_r} + {1'b0, count_r} - {{CW{1'b0}}, take_s};
        if (rst) begin
            rom_en_s = 1'b0;
        end else begin
            rom_en_s = ~redirect_s & ~halt_s & (occupancy_s < DEPTH_W);
        end
        accept_s  = rom_en_s & rom_ready;
        discard_s = rom_rvalid & ((disc_r != CNT_ZERO) | redirect_s);
        push_s    = rom_rvalid & ~discard_s;
        if (rom_rvalid) begin
            disc_reload_s = out_r - CNT_ONE;
        end else begin
            disc_reload_s = out_r;
        end
    end

    // Program counter: redirect wins; otherwise advance on every accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (redirect_s) begin
            pc_r <= target_s;
        end else if (accept_s) begin
            pc_r <= pc_r + 32'd4;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Address tagged onto the next kept response; follows the request stream in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_addr_r <= RESET_PC;
        end else if (redirect_s) begin
            resp_addr_r <= target_s;
        end else if (push_s) begin
            resp_addr_r <= resp_addr_r + 32'd4;
        end else begin
            resp_addr_r <= resp_addr_r;
        end
    end

    // In-flight counter: +1 per accepted request, -1 per response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= CNT_ZERO;
        end else begin
            case ({accept_s, rom_rvalid})
                2'b10:   out_r <= out_r + CNT_ONE;
                2'b01:   out_r <= out_r - CNT_ONE;
                default: out_r <= out_r;
            endcase
        end
    end

    // Discard counter: every response still outstanding after a redirect is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disc_r <= CNT_ZERO;
        end else if (redirect_s) begin
            disc_r <= disc_reload_s;
        end else if (discard_s) begin
            disc_r <= disc_r - CNT_ONE;
        end else begin
            disc_r <= disc_r;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything younger than the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else if (redirect_s) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            head_r <= take_s ? head_r + PTR_ONE : head_r;
            tail_r <= push_s ? tail_r + PTR_ONE : tail_r;
            case ({push_s, take_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are qualified by count_r, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[tail_r] <= resp_addr_r;
            inst_mem_r[tail_r] <= rom_rdata;
        end
    end

    // Head presented to decode; an empty queue shows address 0 and a NOP.
    always_comb begin
        if (id_valid) begin
            id_addr = addr_mem_r[head_r];
            id_inst = inst_mem_r[head_r];
        end else begin
            id_addr = 32'h0000_0000;
            id_inst = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with programmable latency and a scoreboard
// of expected {addr, inst} heads; honours FETCH_ALIGN_CHECK_EN when defined.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam int          DEPTH  = 4;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_ready;
    logic        rom_rvalid;
    logic [31:0] rom_rdata;
    logic        id_valid;
    logic [31:0] id_addr;
    logic [31:0] id_inst;
    logic        fetch_error;

    fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag), .branch_addr(branch_addr),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_ready(rom_ready), .rom_rvalid(rom_rvalid),
        .rom_rdata(rom_rdata), .id_valid(id_valid), .id_addr(id_addr), .id_inst(id_inst),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          disc;
    } req_t;

    req_t        pend_q[$];
    logic [31:0] exp_q[$];
    int          qcount;
    logic [31:0] pc_m;
    bit          halted_m;
    bit          ferr_m;
    int          lat;
    int          cyc;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_F00D;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        exp_q.delete();
        qcount   = 0;
        pc_m     = RST_PC;
        halted_m = 1'b0;
        ferr_m   = 1'b0;
    endtask

    // One clock: drive memory response, check outputs, then advance the model past the rising edge.
    task automatic step();
        bit          take_m;
        bit          redir_m;
        bit          en_m;
        bit          push_m;
        logic [31:0] tgt;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            rom_rvalid = 1'b1;
            rom_rdata  = inst_of(pend_q[0].addr);
        end else begin
            rom_rvalid = 1'b0;
            rom_rdata  = 32'h0000_0000;
        end
        #1;
        take_m  = (qcount > 0) && !stall;
        redir_m = branch_flag && take_m;
        en_m    = !redir_m && !halted_m && (pend_q.size() + qcount - int'(take_m) < DEPTH);
        check_eq("id_valid", {31'd0, id_valid}, {31'd0, qcount > 0});
        if (qcount > 0) begin
            check_eq("id_addr", id_addr, exp_q[0]);
            check_eq("id_inst", id_inst, inst_of(exp_q[0]));
        end else begin
            check_eq("id_addr_empty", id_addr, 32'h0000_0000);
            check_eq("id_inst_empty", id_inst, 32'h0000_0000);
        end
        check_eq("rom_en", {31'd0, rom_en}, {31'd0, en_m});
        check_eq("rom_addr", rom_addr, pc_m);
        check_eq("fetch_error", {31'd0, fetch_error}, {31'd0, ferr_m});
        @(posedge clk);
        if (take_m) void'(exp_q.pop_front());
        if (redir_m) begin
            foreach (pend_q[i]) pend_q[i].disc = 1'b1;
            exp_q.delete();
        end
        push_m = 1'b0;
        if (rom_rvalid) begin
            push_m = !pend_q[0].disc;
            void'(pend_q.pop_front());
        end
        qcount = redir_m ? 0 : qcount + int'(push_m) - int'(take_m);
        if (en_m && rom_ready) begin
            pend_q.push_back('{addr: pc_m, due: cyc + lat, disc: 1'b0});
            exp_q.push_back(pc_m);
            pc_m = pc_m + 32'd4;
        end
        if (redir_m) begin
            tgt  = branch_addr & 32'hFFFF_FFFC;
            pc_m = tgt;
            if (ALIGN_EN && branch_addr[1:0] != 2'b00) begin
                halted_m = 1'b1;
                ferr_m   = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Single-cycle redirect pulse once a head is available (bounded wait).
    task automatic redirect_to(input logic [31:0] a);
        for (int k = 0; k < 12 && qcount == 0; k++) step();
        branch_flag = 1'b1;
        branch_addr = a;
        step();
        branch_flag = 1'b0;
    endtask

    task automatic async_reset_pulse();
        #2;
        rom_rvalid = 1'b0;
        rst        = 1'b1;
        #1;
        check_eq("rst_rom_en", {31'd0, rom_en}, 32'd0);
        check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rst_id_addr", id_addr, 32'h0000_0000);
        check_eq("rst_id_inst", id_inst, 32'h0000_0000);
        check_eq("rst_rom_addr", rom_addr, RST_PC);
        check_eq("rst_fetch_error", {31'd0, fetch_error}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        lat         = 1;
        rst         = 1'b1;
        stall       = 1'b0;
        branch_flag = 1'b0;
        branch_addr = 32'h0000_0000;
        rom_ready   = 1'b1;
        rom_rvalid  = 1'b0;
        rom_rdata   = 32'h0000_0000;
        model_reset();
        #1;
        check_eq("reset_rom_en", {31'd0, rom_en}, 32'd0);
        check_eq("reset_rom_addr", rom_addr, RST_PC);
        check_eq("reset_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("reset_id_addr", id_addr, 32'h0000_0000);
        check_eq("reset_fetch_error", {31'd0, fetch_error}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Streaming with 1-cycle memory.
        run(12);

        // Long stall: issue must stop at the queue bound and the head must hold.
        stall = 1'b1;
        run(10);
        stall = 1'b0;
        run(8);

        // 3-cycle memory, redirect with requests in flight.
        lat = 3;
        run(8);
        redirect_to(32'h0000_2000);
        run(14);

        // Branch ignored under stall, then taken while a response returns.
        lat = 1;
        run(6);
        stall       = 1'b1;
        branch_flag = 1'b1;
        branch_addr = 32'h0000_4000;
        run(2);
        stall = 1'b0;
        step();
        branch_flag = 1'b0;
        run(6);

        // Randomised stall/ready/branch traffic with 2-cycle memory.
        lat = 2;
        for (int k = 0; k < 200; k++) begin
            stall       = ($urandom_range(0, 3) == 0);
            rom_ready   = ($urandom_range(0, 4) != 0);
            branch_flag = ($urandom_range(0, 9) == 0);
            branch_addr = 32'h0000_3000 + (32'($urandom_range(0, 63)) << 2);
            step();
        end
        stall       = 1'b0;
        rom_ready   = 1'b1;
        branch_flag = 1'b0;
        run(6);

        // Asynchronous reset with a full queue, then restart from the reset PC.
        lat   = 1;
        stall = 1'b1;
        run(6);
        async_reset_pulse();
        stall = 1'b0;
        run(8);

        // Misaligned redirect target.
        redirect_to(32'h0000_2002);
        run(8);
        async_reset_pulse();
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the decode stage. It owns the program counter, issues in-order requests to instruction memory through a ready/valid interface, and buffers returned words with their addresses in a small queue. The queue head is presented to decode as `{id_addr, id_inst}`. Decode's `branch_flag`/`branch_addr` redirect the PC and discard all younger fetched or in-flight instructions; decode's `stall_request` holds the queue head.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `QUEUE_DEPTH`, 4: instruction-queue entries; power of two, ≥2. Also caps in-flight plus queued fetches.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset; one clock, asynchronous, active-high.
- `stall` in 1: decode stall (decode `stall_request`); head not consumed.
- `branch_flag` in 1: decode redirect request.
- `branch_addr` in 32: redirect target.
- `rom_en` out 1: fetch request valid.
- `rom_addr` out 32: fetch address (the PC register).
- `rom_ready` in 1: memory accepts the request this cycle.
- `rom_rvalid` in 1: response valid; responses return in request order, ≥1 cycle after acceptance.
- `rom_rdata` in 32: response instruction word.
- `id_valid` out 1: queue head valid.
- `id_addr` out 32: head instruction address; 0 when empty.
- `id_inst` out 32: head instruction; 0 (NOP) when empty.
- `fetch_error` out 1: sticky misaligned-target flag; only with `FETCH_ALIGN_CHECK_EN`, else tied 0.

## Operation
- State: `pc`, queue (addr+inst, head/tail pointers, count `q`), in-flight counter `o`, discard counter `d` (d ≤ o).
- Consume: `take = id_valid & ~stall`. The head pops on `take`.
- Redirect: `redirect = branch_flag & take`. `branch_flag` is ignored while stalled or while the queue is empty.
- Issue: `rom_en = ~redirect & ~halted & (o + q - take < QUEUE_DEPTH)`. On `rom_en & rom_ready`: `o++` and `pc <= pc + 4`. The add wraps modulo 2^32.
- Response handling:
  - On `rom_rvalid`: `o--`.
  - If `d > 0` (or `redirect` in the same cycle), the word is discarded and `d--` applies.
  - Otherwise `{address, rom_rdata}` is pushed at the tail. The stored address is tracked by a response-address register that starts at the PC of the first issued request and advances by 4 per accepted response.
- On `redirect`:
  - Queue cleared.
  - `pc <= branch_addr`.
  - `d <= o - rom_rvalid`, i.e. every response still outstanding after this cycle is discarded.
  - The response-address register reloads with `branch_addr`.
- No branch delay slot: every instruction younger than the redirecting one is discarded.
- Simultaneous push and pop in one cycle is legal; count is unchanged.
- Overflow is impossible by construction: the issue rule bounds `o + q`. A push while full is a design error and the bench asserts it never happens.

## Timing
- Reset values:
  - `pc = RESET_PC`; `q = o = d = 0`.
  - `rom_en = 0` while `rst` is high; `rom_addr = RESET_PC`.
  - `id_valid = 0`, `id_addr = 0`, `id_inst = 0`, `fetch_error = 0`.
- First request: `rom_en = 1` in the first cycle after `rst` deasserts.
- Latency: `rom_rvalid` in cycle n gives `id_valid`/head visible in cycle n+1 (registered queue, no bypass).
- Throughput: with 1-cycle memory and no stall, one instruction per cycle once the pipe fills. Request at t, response at t+1, head at t+2.
- Redirect penalty with 1-cycle memory: redirect at cycle b, target requested at b+1, response at b+2, `id_valid` at b+3.
- `rom_en` depends combinationally on `stall`, `branch_flag`, and the head state.
- Reset mid-operation: all state cleared immediately. Memory shares `rst`, so no stale responses arrive afterwards.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `branch_addr[1:0] != 0` clears the queue and sets `fetch_error`.
  - It also sets `halted`, which forces `rom_en = 0`; outstanding responses are still discarded via `d`.
  - `fetch_error` and `halted` hold until `rst`.
- Not defined:
  - `branch_addr[1:0]` is forced to 0 on redirect.
  - `fetch_error` is tied 0 and no halt logic exists.

## Test plan
- Reset, `RESET_PC = 32'h0000_1000`, 1-cycle memory, no stall -> requests at 0x1000, 0x1004, 0x1008 on consecutive cycles; `id_valid` from cycle 3 after reset release; `id_addr` sequence 0x1000, 0x1004, …, one per cycle.
- Hold `stall = 1` for 10 cycles with `rom_ready = 1` -> `o + q` never exceeds 4; `id_addr` frozen; no push while full; stream resumes in order on release.
- 3-cycle memory latency, redirect to 0x2000 while 2 requests are in flight -> both late responses discarded (`d` reaches 0); next head is 0x2000, followed by 0x2004.
- `branch_flag = 1` with `stall = 1` -> no redirect, `pc` unchanged. Same cycle with `stall = 0` and `rom_rvalid = 1` -> the returning word is discarded.
- `rst` pulsed asynchronously mid-stream with full queue -> `id_valid`, `rom_en`, and counters go to 0 immediately; fetch restarts at `RESET_PC`.
- With `FETCH_ALIGN_CHECK_EN`: redirect to 0x2002 -> `fetch_error = 1` next cycle, `rom_en` stays 0, `id_valid = 0` until `rst`. Without the macro: fetch resumes at 0x2000.
